nr_div_stream: RTL and testbench

- Parametrised, block-streamed radix-2 non-restoring divider for the L-function path: computes q = x / y and r = x mod y.
- x is N bits, y is M bits. Both operands enter, and both results leave, as BLOCK-bit beats, least-significant first.
- Adds over the previous divider: valid/ready backpressure on both sides, a correct M-bit remainder output, explicit divide-by-zero handling, and arbitrary N/M/BLOCK.

---
 rtl/nr_div_stream.sv | 161 ++++++++++++++++
 tb/tb_nr_div_stream.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nr_div_stream.sv
// Block-streamed radix-2 non-restoring divider: q = x / y, r = x mod y.
// Operands enter and results leave as BLOCK-bit beats, least-significant first.
module nr_div_stream #(
  parameter int unsigned N     = 4096,
  parameter int unsigned M     = 2048,
  parameter int unsigned BLOCK = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLOCK-1:0] in_x,
  input  logic [BLOCK-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLOCK-1:0] out_q,
  output logic [BLOCK-1:0] out_r,
  output logic             out_last,
  output logic             out_div0
);

  localparam int unsigned NCNT = N / BLOCK;
  localparam int unsigned MCNT = M / BLOCK;
  localparam int unsigned BW   = (NCNT > 1) ? $clog2(NCNT) : 1;
  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW   = M + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ITER,
    S_FIX,
    S_OUT
  } state_t;

  state_t        state;
  logic [N-1:0]  x_sh;
  logic [N-1:0]  q_sh;
  logic [M-1:0]  y_reg;
  logic [M-1:0]  r_sh;
  logic [RW-1:0] rem;
  logic [BW-1:0] beat;
  logic [IW-1:0] it;

  logic [RW-1:0] d_ext;
  logic [RW-1:0] t_val;
  logic [RW-1:0] rem_step;
  logic [RW-1:0] rem_fix;
  logic [M-1:0]  r_src;
  logic          load_beat0;

  // Partial remainder is two's complement; its MSB is the sign.
  always_comb begin
    d_ext      = {2'b00, y_reg};
    t_val      = {rem[RW-2:0], x_sh[N-1]};
    rem_step   = rem[RW-1] ? (t_val + d_ext) : (t_val - d_ext);
    rem_fix    = rem[RW-1] ? (rem + d_ext) : rem;
    r_src      = (state == S_FIX) ? rem_fix[M-1:0] : r_sh;
    load_beat0 = (state == S_FIX) || ((state == S_OUT) && !out_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_last  <= 1'b0;
      out_div0  <= 1'b0;
      beat      <= '0;
      it        <= '0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            x_sh <= N'({in_x, x_sh} >> BLOCK);
            if (32'(beat) < MCNT) begin
              y_reg <= M'({in_y, y_reg} >> BLOCK);
            end
            if (beat == BW'(NCNT - 1)) begin
              state    <= S_CHECK;
              in_ready <= 1'b0;
              beat     <= '0;
            end else begin
              state <= S_LOAD;
              beat  <= beat + 1'b1;
            end
          end
        end

        S_CHECK: begin
          if (y_reg == '0) begin
            q_sh     <= '1;
            r_sh     <= '0;
            out_div0 <= 1'b1;
            state    <= S_OUT;
          end else begin
            rem   <= '0;
            it    <= '0;
            state <= S_ITER;
          end
        end

        // One quotient bit per cycle, dividend consumed MSB first.
        S_ITER: begin
          rem  <= rem_step;
          x_sh <= x_sh << 1;
          q_sh <= {q_sh[N-2:0], ~rem_step[RW-1]};
          it   <= it + 1'b1;
          if (it == IW'(N - 1)) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          rem   <= rem_fix;
          state <= S_OUT;
        end

        S_OUT: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              out_q     <= '0;
              out_r     <= '0;
              out_last  <= 1'b0;
              out_div0  <= 1'b0;
              in_ready  <= 1'b1;
              beat      <= '0;
            end else begin
              out_q    <= q_sh[BLOCK-1:0];
              q_sh     <= q_sh >> BLOCK;
              out_r    <= r_sh[BLOCK-1:0];
              r_sh     <= r_sh >> BLOCK;
              beat     <= beat + 1'b1;
              out_last <= (BW'(beat + 1'b1) == BW'(NCNT - 1));
            end
          end
        end

        default: state <= S_IDLE;
      endcase

      // First result beat: straight out of FIX, or on the first OUT cycle after a divide-by-zero.
      if (load_beat0) begin
        out_valid <= 1'b1;
        out_q     <= q_sh[BLOCK-1:0];
        q_sh      <= q_sh >> BLOCK;
        out_r     <= r_src[BLOCK-1:0];
        r_sh      <= r_src >> BLOCK;
        beat      <= '0;
        out_last  <= (NCNT == 1);
      end
    end
  end

endmodule

// File: tb/tb_nr_div_stream.sv
// Directed bench for nr_div_stream: a 16/8/4 instance for protocol and corner cases,
// plus a default-size instance for full-width identities.
module tb_nr_div_stream;

  localparam int unsigned SN  = 16;
  localparam int unsigned SM  = 8;
  localparam int unsigned SB  = 4;
  localparam int unsigned SNC = SN / SB;
  localparam int unsigned SMC = SM / SB;
  localparam int unsigned BN  = 4096;
  localparam int unsigned BM  = 2048;
  localparam int unsigned BB  = 128;
  localparam int unsigned BNC = BN / BB;
  localparam int unsigned BMC = BM / BB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          in_valid, in_ready, out_valid, out_ready, out_last, out_div0;
  logic [SB-1:0] in_x, in_y, out_q, out_r;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_out_div0;
  logic [BB-1:0] b_in_x, b_in_y, b_out_q, b_out_r;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t_last = 0;

  nr_div_stream #(.N(SN), .M(SM), .BLOCK(SB)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .out_last(out_last), .out_div0(out_div0)
  );

  nr_div_stream #(.N(BN), .M(BM), .BLOCK(BB)) u_big (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x), .in_y(b_in_y),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_q(b_out_q), .out_r(b_out_r),
    .out_last(b_out_last), .out_div0(b_out_div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  BB'(in_ready),  BB'(1'b0));
    chk({tag, "_out_valid"}, BB'(out_valid), BB'(1'b0));
    chk({tag, "_out_q"},     BB'(out_q),     BB'(1'b0));
    chk({tag, "_out_r"},     BB'(out_r),     BB'(1'b0));
    chk({tag, "_out_last"},  BB'(out_last),  BB'(1'b0));
    chk({tag, "_out_div0"},  BB'(out_div0),  BB'(1'b0));
  endtask

  task automatic s_send(input logic [SN-1:0] x, input logic [SM-1:0] y, input int unsigned gap);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < SNC; k++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(gap, 0)) tick();
      in_valid = 1'b1;
      in_x     = x[k*SB +: SB];
      in_y     = (k < SMC) ? y[k*SB +: SB] : SB'($urandom);
      for (int b = 0; b < 50 && in_ready !== 1'b1; b++) tick();
      if (in_ready !== 1'b1) ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    t_last   = cyc;
    chk("s_accept", BB'(ok), BB'(1'b1));
  endtask

  task automatic s_recv(input logic [SN-1:0] eq, input logic [SM-1:0] er, input logic ediv0,
                        input int elat, input int unsigned stall);
    logic [SN-1:0] er_w;
    logic [SB-1:0] pq, pr;
    logic          pl, pd, ready_ok, stable_ok;
    int            lat;
    er_w      = SN'(er);
    ready_ok  = 1'b1;
    stable_ok = 1'b1;
    out_ready = 1'b0;
    for (int b = 0; b < SN + 10 && out_valid !== 1'b1; b++) begin
      if (in_ready !== 1'b0) ready_ok = 1'b0;
      tick();
    end
    lat = cyc - t_last;
    chk("s_valid_rise", BB'(out_valid), BB'(1'b1));
    chk("s_latency", BB'(lat), BB'(elat));
    for (int k = 0; k < SNC; k++) begin
      repeat ($urandom_range(stall, 0)) begin
        pq = out_q; pr = out_r; pl = out_last; pd = out_div0;
        tick();
        if (out_valid !== 1'b1 || out_q !== pq || out_r !== pr || out_last !== pl ||
            out_div0 !== pd || in_ready !== 1'b0) stable_ok = 1'b0;
      end
      chk($sformatf("s_q_beat%0d", k), BB'(out_q), BB'(eq[k*SB +: SB]));
      chk($sformatf("s_r_beat%0d", k), BB'(out_r), BB'(er_w[k*SB +: SB]));
      chk($sformatf("s_last%0d", k), BB'(out_last), BB'(k == SNC - 1));
      chk($sformatf("s_div0_%0d", k), BB'(out_div0), BB'(ediv0));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("s_stall_stable", BB'(stable_ok), BB'(1'b1));
    chk("s_ready_low_busy", BB'(ready_ok), BB'(1'b1));
    chk("s_done_valid", BB'(out_valid), BB'(1'b0));
    chk("s_done_ready", BB'(in_ready), BB'(1'b1));
  endtask

  task automatic b_op(input logic [BN-1:0] x, input logic [BM-1:0] y,
                      input logic [BN-1:0] eq, input logic [BM-1:0] er);
    logic [BN-1:0] er_w;
    logic          ok;
    int            lat;
    er_w = BN'(er);
    ok   = 1'b1;
    for (int k = 0; k < BNC; k++) begin
      b_in_valid = 1'b1;
      b_in_x     = x[k*BB +: BB];
      b_in_y     = (k < BMC) ? y[k*BB +: BB] : {4{$urandom}};
      for (int b = 0; b < 50 && b_in_ready !== 1'b1; b++) tick();
      if (b_in_ready !== 1'b1) ok = 1'b0;
      tick();
    end
    b_in_valid = 1'b0;
    t_last     = cyc;
    chk("b_accept", BB'(ok), BB'(1'b1));
    for (int b = 0; b < BN + 20 && b_out_valid !== 1'b1; b++) tick();
    lat = cyc - t_last;
    chk("b_latency", BB'(lat), BB'(BN + 2));
    b_out_ready = 1'b1;
    for (int k = 0; k < BNC; k++) begin
      chk($sformatf("b_q_beat%0d", k), b_out_q, eq[k*BB +: BB]);
      chk($sformatf("b_r_beat%0d", k), b_out_r, er_w[k*BB +: BB]);
      chk($sformatf("b_last%0d", k), BB'(b_out_last), BB'(k == BNC - 1));
      tick();
    end
    b_out_ready = 1'b0;
    chk("b_done_valid", BB'(b_out_valid), BB'(1'b0));
  endtask

  initial begin
    logic [SN-1:0] rx, eq;
    logic [SM-1:0] ry, er;
    logic [BM-1:0] ones_m;
    logic [BN-1:0] ones_n;

    in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_x = '0; b_in_y = '0; b_out_ready = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    chk_reset("por");
    rst = 1'b0;
    tick();
    chk("post_reset_ready", BB'(in_ready), BB'(1'b1));

    // 0x1234 / 7 = 0x0299 rem 5; result 18 cycles after last input beat.
    s_send(16'h1234, 8'h07, 0);
    s_recv(16'h0299, 8'h05, 1'b0, 18, 0);

    // Divide by zero: all-ones quotient, zero remainder, 2-cycle latency.
    s_send(16'hABCD, 8'h00, 2);
    s_recv(16'hFFFF, 8'h00, 1'b1, 2, 2);

    // x < y, y = 1, and y = max.
    s_send(16'h0005, 8'hFF, 0);
    s_recv(16'h0000, 8'h05, 1'b0, 18, 1);
    s_send(16'hFFFF, 8'h01, 1);
    s_recv(16'hFFFF, 8'h00, 1'b0, 18, 0);
    s_send(16'hFFFF, 8'hFF, 0);
    s_recv(16'h0101, 8'h00, 1'b0, 18, 1);

    // Randomised operands with input gaps and output stalls.
    for (int i = 0; i < 30; i++) begin
      rx = SN'($urandom);
      ry = (i % 7 == 3) ? 8'h00 : SM'($urandom);
      if (ry == 8'h00) begin
        eq = 16'hFFFF;
        er = 8'h00;
      end else begin
        eq = rx / SN'(ry);
        er = SM'(rx % SN'(ry));
      end
      s_send(rx, ry, 3);
      s_recv(eq, er, ry == 8'h00, (ry == 8'h00) ? 2 : 18, 3);
    end

    // Reset during iteration.
    s_send(16'h1234, 8'h07, 0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk_reset("rst_iter");
    rst = 1'b0;
    tick();
    chk("rst_iter_ready", BB'(in_ready), BB'(1'b1));

    // Reset during output: 0xABCD / 3 = 0x3944 rem 1.
    s_send(16'hABCD, 8'h03, 0);
    for (int b = 0; b < 30 && out_valid !== 1'b1; b++) tick();
    chk("pre_rst_beat0", BB'(out_q), BB'(4'h4));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pre_rst_beat1", BB'(out_q), BB'(4'h4));
    rst = 1'b1;
    tick();
    chk_reset("rst_out");
    rst = 1'b0;
    tick();
    s_send(16'h1234, 8'h07, 1);
    s_recv(16'h0299, 8'h05, 1'b0, 18, 2);

    // Full width: (2^4096-1)/(2^2048-1) = 2^2048+1 exactly.
    ones_m = '1;
    ones_n = '1;
    b_op(ones_n, ones_m, (BN'(1) << BM) | BN'(1), '0);
    b_op(ones_n, BM'(1), ones_n, '0);
    b_op(BN'(ones_m - BM'(1)), ones_m, '0, ones_m - BM'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
